// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared definitions for the WISC instruction-fetch stage.
//               Holds the default widths, the HLT opcode, the bubble
//               instruction and the fetch FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 16;

    localparam logic [3:0]  OPC_HLT   = 4'b1111;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    // True when the top nibble of an instruction is the HLT opcode.
    function automatic logic is_hlt(input logic [3:0] opc);
        return opc == OPC_HLT;
    endfunction

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_ifid_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_reg
// Description : Pipeline register between two stages with write enable and
//               bubble/flush insertion. Priority: flush > hold > load > bubble.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush_i      : insert a bubble regardless of write_en_i
//   write_en_i   : 0 = hold every field
//   load_i       : capture instr_i / pc_plus2_i as a valid entry
//   instr_i      : incoming instruction
//   pc_plus2_i   : incoming PC+2
//   instr_o, pc_plus2_o, valid_o : registered contents
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg #(
    parameter int                  INSTR_W      = 16,
    parameter int                  ADDR_W       = 16,
    parameter logic [INSTR_W-1:0]  BUBBLE_INSTR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               write_en_i,
    input  logic               load_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_plus2_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_plus2_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_plus2_q;
    logic               valid_q;

    // A bubble leaves pc_plus2 untouched; it is meaningless while valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= '0;
            pc_plus2_q <= '0;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            instr_q    <= BUBBLE_INSTR;
            valid_q    <= 1'b0;
        end else if (write_en_i) begin
            if (load_i) begin
                instr_q    <= instr_i;
                pc_plus2_q <= pc_plus2_i;
                valid_q    <= 1'b1;
            end else begin
                instr_q    <= BUBBLE_INSTR;
                valid_q    <= 1'b0;
            end
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus2_o = pc_plus2_q;
    assign valid_o    = valid_q;

endmodule : ifid_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage of the 5-stage WISC pipeline. Owns the
//               PC, issues fetches over a req/valid handshake (hit may return
//               in the same cycle), handles misses, redirects that arrive
//               during a miss, and HLT. Drives the IF/ID register.
//   pc_write_en / ifid_write_en : hazard-unit stalls
//   branch_taken / branch_target: redirect resolved in ID
//   imem_req / imem_addr        : fetch request; address stable while waiting
//   imem_rdata / imem_valid     : returned instruction
//   ifid_instr / ifid_pc_plus2 / ifid_valid : IF/ID register contents
//   halted                      : HLT fetched, fetch stopped
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int               ADDR_W   = ADDR_W_DEF,
    parameter int               INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_write_en,
    input  logic               ifid_write_en,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc_plus2,
    output logic               ifid_valid,
    output logic               halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              pend_q, pend_d;
    logic              halted_q, halted_d;

    logic [ADDR_W-1:0] w_pc_plus2;
    logic              w_is_hlt;
    logic              w_accept;

    assign w_pc_plus2 = pc_q + ADDR_W'(2);
    assign w_is_hlt   = is_hlt(imem_rdata[INSTR_W-1 -: 4]);

    // Data is only consumed when nothing newer (branch, pending redirect,
    // stall) overrides it.
    assign w_accept = (state_q != HALTED) && imem_valid && pc_write_en &&
                      !branch_taken && !pend_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            tgt_q    <= '0;
            pend_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            pend_q   <= pend_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        pend_d   = pend_q;
        halted_d = halted_q;
        imem_req = 1'b1;

        case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    // No request outstanding yet, so the PC can move now.
                    pc_d = branch_target;
                end else if (!imem_valid) begin
                    state_d = WAIT;
                end else if (w_accept) begin
                    if (w_is_hlt) begin
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = w_pc_plus2;
                    end
                end
            end

            WAIT: begin
                if (imem_valid) begin
                    state_d = FETCH;
                    if (branch_taken) begin
                        pc_d   = branch_target;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        // Returned data belongs to the squashed path.
                        pc_d   = tgt_q;
                        pend_d = 1'b0;
                    end else if (w_accept) begin
                        if (w_is_hlt) begin
                            state_d  = HALTED;
                            halted_d = 1'b1;
                        end else begin
                            pc_d = w_pc_plus2;
                        end
                    end
                end else if (branch_taken) begin
                    // Address must stay put until the memory answers.
                    tgt_d  = branch_target;
                    pend_d = 1'b1;
                end
            end

            HALTED: begin
                imem_req = 1'b0;
                if (branch_taken) begin
                    pc_d     = branch_target;
                    halted_d = 1'b0;
                    state_d  = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign halted    = halted_q;

    ifid_reg #(
        .INSTR_W      (INSTR_W),
        .ADDR_W       (ADDR_W),
        .BUBBLE_INSTR (INSTR_W'(NOP_INSTR))
    ) u_ifid_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (branch_taken),
        .write_en_i (ifid_write_en),
        .load_i     (w_accept),
        .instr_i    (imem_rdata),
        .pc_plus2_i (w_pc_plus2),
        .instr_o    (ifid_instr),
        .pc_plus2_o (ifid_pc_plus2),
        .valid_o    (ifid_valid)
    );

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A stimulus process drives
//               one cycle at a time and pushes the expected post-edge view
//               (from a transaction-level fetch model) into a scoreboard; a
//               monitor pops and compares after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        pc_write_en;
    logic        ifid_write_en;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;

    fetch_stage #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_write_en   (pc_write_en),
        .ifid_write_en (ifid_write_en),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model (instruction-level view) -------------
    typedef struct {
        logic        req;
        logic [15:0] addr;
        logic        v;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        halted;
    } exp_t;

    exp_t sbq[$];

    logic [15:0] m_pc, m_tgt, m_instr, m_pc2;
    logic        m_miss, m_pend, m_halt, m_v;

    task automatic model_reset();
        m_pc = 16'h0000; m_tgt = '0; m_miss = 0; m_pend = 0; m_halt = 0;
        m_v = 0; m_instr = '0; m_pc2 = '0;
    endtask

    task automatic model_step(input logic pcw, input logic ifw, input logic br,
                              input logic [15:0] tgt, input logic vld,
                              input logic [15:0] rd);
        logic take;
        exp_t e;
        // An instruction is taken only by a live fetch nobody is overriding.
        take = !m_halt && vld && pcw && !br && !m_pend;
        if (br) begin
            m_v = 0; m_instr = '0;
        end else if (ifw) begin
            if (take) begin m_v = 1; m_instr = rd; m_pc2 = m_pc + 16'd2; end
            else begin m_v = 0; m_instr = '0; end
        end
        if (m_halt) begin
            if (br) begin m_pc = tgt; m_halt = 0; end
        end else if (br) begin
            if (m_miss && !vld) begin m_pend = 1; m_tgt = tgt; end
            else begin m_pc = tgt; m_miss = 0; m_pend = 0; end
        end else if (m_pend) begin
            if (vld) begin m_pc = m_tgt; m_pend = 0; m_miss = 0; end
        end else if (vld) begin
            m_miss = 0;
            if (take) begin
                if (rd[15:12] == 4'hF) m_halt = 1;
                else m_pc = m_pc + 16'd2;
            end
        end else begin
            m_miss = 1;
        end
        e.req = !m_halt; e.addr = m_pc; e.v = m_v; e.instr = m_instr;
        e.pc2 = m_pc2; e.halted = m_halt;
        sbq.push_back(e);
    endtask

    // Drive one cycle: inputs are applied 2ns after an edge, held through the next.
    task automatic cyc(input logic pcw, input logic ifw, input logic br,
                       input logic [15:0] tgt, input logic vld, input logic [15:0] rd);
        pc_write_en = pcw; ifid_write_en = ifw; branch_taken = br;
        branch_target = tgt; imem_valid = vld; imem_rdata = rd;
        model_step(pcw, ifw, br, tgt, vld, rd);
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".req"},    {15'd0, imem_req},   16'd1);
        chk({tag, ".addr"},   imem_addr,           16'h0000);
        chk({tag, ".valid"},  {15'd0, ifid_valid}, 16'd0);
        chk({tag, ".instr"},  ifid_instr,          16'h0000);
        chk({tag, ".pc2"},    ifid_pc_plus2,       16'h0000);
        chk({tag, ".halted"}, {15'd0, halted},     16'd0);
    endtask

    // ---------------- monitor ----------------------------------------------
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (rst_n && sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            chk("imem_req", {15'd0, imem_req}, {15'd0, mon_e.req});
            if (mon_e.req) chk("imem_addr", imem_addr, mon_e.addr);
            chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, mon_e.v});
            chk("ifid_instr", ifid_instr, mon_e.instr);
            if (mon_e.v) chk("ifid_pc_plus2", ifid_pc_plus2, mon_e.pc2);
            chk("halted", {15'd0, halted}, {15'd0, mon_e.halted});
        end
    end

    // ---------------- stimulus ---------------------------------------------
    initial begin
        logic        r_pcw, r_ifw, r_br, r_vld;
        logic [15:0] r_tgt, r_rd;

        rst_n = 0; pc_write_en = 1; ifid_write_en = 1; branch_taken = 0;
        branch_target = '0; imem_valid = 0; imem_rdata = '0;
        model_reset();
        #3;
        check_reset("por");
        @(posedge clk); #2;
        rst_n = 1;

        // back-to-back hits from reset
        cyc(1, 1, 0, 16'h0, 1, 16'h1234);
        cyc(1, 1, 0, 16'h0, 1, 16'h2345);
        // hazard stall at pc=4
        cyc(0, 0, 0, 16'h0, 1, 16'h3456);
        cyc(0, 0, 0, 16'h0, 1, 16'h3456);
        cyc(1, 1, 0, 16'h0, 1, 16'h3456);
        cyc(1, 1, 0, 16'h0, 1, 16'h4567);
        // three-cycle miss at pc=8
        repeat (3) cyc(1, 1, 0, 16'h0, 0, 16'hDEAD);
        cyc(1, 1, 0, 16'h0, 1, 16'h5678);
        cyc(1, 1, 0, 16'h0, 1, 16'h6001);
        cyc(1, 1, 0, 16'h0, 1, 16'h6002);
        cyc(1, 1, 0, 16'h0, 1, 16'h6003);
        // redirect during a miss at pc=0x10
        cyc(1, 1, 0, 16'h0,    0, 16'hDEAD);
        cyc(1, 1, 1, 16'h0040, 0, 16'hDEAD);
        cyc(1, 1, 0, 16'h0,    0, 16'hDEAD);
        cyc(1, 1, 0, 16'h0,    1, 16'h7777);
        cyc(1, 1, 0, 16'h0,    1, 16'h1111);
        // redirect while fetching, then HLT at 0x20
        cyc(1, 1, 1, 16'h0020, 1, 16'h2222);
        cyc(1, 1, 0, 16'h0,    1, 16'hF000);
        cyc(1, 1, 0, 16'h0,    1, 16'h3333);
        cyc(1, 1, 0, 16'h0,    0, 16'h3333);
        cyc(1, 1, 1, 16'h0080, 0, 16'h0000);
        // PC wrap at the top of the address space
        cyc(1, 1, 1, 16'hFFFE, 1, 16'h4444);
        cyc(1, 1, 0, 16'h0,    1, 16'h5555);
        cyc(1, 1, 0, 16'h0,    1, 16'h5556);
        // asynchronous reset in the middle of a miss
        cyc(1, 1, 0, 16'h0, 0, 16'hDEAD);
        imem_valid = 0;
        #1;
        rst_n = 0;
        #1;
        check_reset("rst_mid_miss");
        model_reset();
        @(posedge clk); #2;
        rst_n = 1;
        cyc(1, 1, 0, 16'h0, 1, 16'h0ABC);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r_pcw = ($urandom_range(0, 9) < 8);
            r_ifw = ($urandom_range(0, 9) < 8);
            r_br  = ($urandom_range(0, 11) == 0);
            r_tgt = 16'($urandom) & 16'hFFFE;
            r_vld = ($urandom_range(0, 9) < 6);
            r_rd  = 16'($urandom);
            if ($urandom_range(0, 29) == 0) r_rd[15:12] = 4'hF;
            else if (r_rd[15:12] == 4'hF) r_rd[15:12] = 4'h0;
            cyc(r_pcw, r_ifw, r_br, r_tgt, r_vld, r_rd);
        end

        @(posedge clk); #2;
        chk("scoreboard_drained", 16'(sbq.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fetch_stage
`default_nettype wire
